// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for both ends of the gcd req/ack protocol.
//   GCD_W             operand / result width on the AB and C buses
//   gcd_init_state_t  requester (gcd_initiator) FSM states
//   gcd_resp_state_t  responder (gcd) FSM states, kept here so both sides
//                     of the protocol are defined in one place
package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    REL_A,
    REQ_B,
    REL_B,
    DONE
  } gcd_init_state_t;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_ACK_A,
    RSP_WAIT_B,
    RSP_CALC,
    RSP_ACK_C
  } gcd_resp_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value instead of wrapping.
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   clr         synchronous clear to 0 (wins over en)
//   en          count enable
//   q           current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && !(&q)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/gcd_initiator.sv
// gcd_initiator: requester-side controller for the gcd responder.
// Takes one (A, B) pair from a valid/ready source, sends A then B over the
// shared AB bus with a four-phase req/ack handshake, captures C, and offers
// the result plus the responder latency on a valid/ready output port.
//   clk, reset                  rising-edge clock, async active-high reset
//   in_valid/in_ready/in_a/in_b operand pair input
//   out_valid/out_ready         result handshake
//   out_c, out_cycles           gcd result and latency (edges in REQ_A..REL_B)
//   req/ack/AB/C                four-phase link to the gcd responder
module gcd_initiator
  import gcd_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [GCD_W-1:0] in_a,
  input  logic [GCD_W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [GCD_W-1:0] out_c,
  output logic [CNT_W-1:0] out_cycles,
  output logic             req,
  input  logic             ack,
  output logic [GCD_W-1:0] AB,
  input  logic [GCD_W-1:0] C
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  gcd_init_state_t  r_state;
  logic [GCD_W-1:0] r_a, r_b, r_ab, r_c;
  logic [CNT_W-1:0] r_cycles;
  logic             r_req, r_in_ready, r_out_valid;

  logic             w_bypass, w_clr, w_en;
  logic [CNT_W-1:0] w_cnt, w_cnt_inc;

  // gcd(0,x) = x and gcd(0,0) = 0, so a zero operand never needs the responder.
  assign w_bypass = (in_a == '0) || (in_b == '0);
  assign w_clr    = (r_state == IDLE) && in_valid && !w_bypass;
  assign w_en     = (r_state == REQ_A) || (r_state == REL_A) ||
                    (r_state == REQ_B) || (r_state == REL_B);

  sat_counter #(.WIDTH(CNT_W)) u_lat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .q     (w_cnt)
  );

  // The REL_B exit edge is itself a counted edge but the counter only shows
  // it one cycle later, so capture the saturated next value instead.
  assign w_cnt_inc = (&w_cnt) ? w_cnt : w_cnt + CNT_ONE;

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking = would let later lines see half-updated state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_ab        <= '0;
      r_c         <= '0;
      r_cycles    <= '0;
      r_req       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ab <= '0;
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_in_ready <= 1'b0;
            if (w_bypass) begin
              r_c         <= in_a | in_b;
              r_cycles    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_ab    <= in_a;
              r_req   <= 1'b1;
              r_state <= REQ_A;
            end
          end
        end
        REQ_A: if (ack) begin
          r_req   <= 1'b0;
          r_state <= REL_A;
        end
        REL_A: if (!ack) begin
          r_ab    <= r_b;
          r_req   <= 1'b1;
          r_state <= REQ_B;
        end
        REQ_B: if (ack) begin
          r_c     <= C;
          r_req   <= 1'b0;
          r_state <= REL_B;
        end
        REL_B: if (!ack) begin
          r_cycles    <= w_cnt_inc;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_req       <= 1'b0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_c      = r_c;
  assign out_cycles = r_cycles;
  assign req        = r_req;
  assign AB         = r_ab;

endmodule

// File: doc/gcd_initiator.md
# gcd_initiator

Requester-side controller for the `gcd` block. It accepts one operand pair (A, B) per transaction from an upstream valid/ready source and drives the `gcd` four-phase req/ack protocol, sending A, then B, over the shared 16-bit `AB` bus. It captures the result `C`, measures transaction latency in clock cycles, and presents result and latency downstream on a valid/ready port. It sits between the system producer and the `gcd` responder; both blocks share `clk` and `reset`.

## Interface
Parameters:
- `CNT_W`, default 32: width of the latency counter.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  initiator can accept a pair.
- `in_a`  in  16  operand A, unsigned.
- `in_b`  in  16  operand B, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_c`  out  16  gcd(A, B).
- `out_cycles`  out  CNT_W  responder latency of this transaction, in cycles.
- `req`  out  1  request to `gcd`.
- `ack`  in  1  acknowledge from `gcd`.
- `AB`  out  16  operand bus to `gcd`.
- `C`  in  16  result from `gcd`. Valid while `ack`=1 in phase B.

## Operation
- The design has a Moore FSM with six states. `req`, `AB`, `in_ready` and `out_valid` decode from the state and registers only. They never depend combinationally on inputs.
- **IDLE**: `in_ready`=1, `req`=0, `AB`=0.
  - On `in_valid`=1, latch `in_a` and `in_b` into `reg_a` and `reg_b`.
  - If either operand is 0, bypass the responder:
    - `out_c` = `reg_a` | `reg_b` (gcd(0,x)=x, gcd(0,0)=0).
    - `out_cycles`=0.
    - Go to DONE.
  - Otherwise, clear the counter and go to REQ_A.
- **REQ_A**: `req`=1, `AB`=`reg_a`. When `ack`=1, go to REL_A.
- **REL_A**: `req`=0, `AB`=`reg_a` held. When `ack`=0, go to REQ_B.
- **REQ_B**: `req`=1, `AB`=`reg_b`. When `ack`=1, latch `C` into `out_c` and go to REL_B.
- **REL_B**: `req`=0, `AB`=`reg_b` held. When `ack`=0, latch the counter into `out_cycles` and go to DONE.
- **DONE**: `out_valid`=1, and `out_c` and `out_cycles` are stable. When `out_ready`=1, go to IDLE.
- Counter behaviour:
  - The counter increments every cycle in REQ_A, REL_A, REQ_B and REL_B.
  - It saturates at 2^CNT_W−1 and does not wrap.
- Only one transaction is in flight at a time. `in_valid` outside IDLE is ignored (`in_ready`=0), with no buffering.
- There is no timeout: a responder that never acknowledges holds the FSM in its current state indefinitely.

## Timing
- Reset values:
  - state IDLE.
  - `req`=0, `AB`=0.
  - `in_ready`=1, `out_valid`=0.
  - `out_c`=0, `out_cycles`=0.
  - `reg_a`, `reg_b` and the counter are 0.
- Reset asserted mid-transaction returns to IDLE immediately and drops `req`. `gcd` shares the same reset, so the protocol restarts cleanly.
- Accept in IDLE at edge k: `req`=1 is visible in cycle k+1.
- Bypass accept at edge k: `out_valid`=1 in cycle k+1.
- Each `ack` transition is sampled at a clock edge. The FSM advances at that edge, so the next `req` edge follows one cycle later.
- `AB` changes only in IDLE, at entry to REQ_A, and at entry to REQ_B. It is stable throughout each req-high phase and its release phase.
- Output handshake:
  - A result transfers at the edge where `out_valid` and `out_ready` are both 1.
  - `in_ready` returns in the following cycle.
  - Minimum back-to-back gap: one idle cycle between a result transfer and the next accept.
- `out_cycles` = number of edges spent in REQ_A through REL_B.
  - With an ideal responder that acks on the cycle after each `req` change and computes in 0 extra cycles, `out_cycles` = 4.

## Structure
- Shared package `gcd_pkg`:
  - `GCD_W` = 16.
  - `gcd_init_state_t` (IDLE, REQ_A, REL_A, REQ_B, REL_B, DONE; 3-bit).
  - The responder state enum, so both ends of the protocol live together.
- Sub-module `sat_counter` (parameter width, inputs `clr` and `en`, output `q`) implements the latency counter. Everything else is in one module.

## Test plan
- in (12, 18), responder model acking one cycle after each `req` edge → phases A then B observed on `AB`, `out_c`=6, `out_cycles`=4, `req` low at end.
- in (0, 35) → no `req` pulse, `out_valid` one cycle after accept, `out_c`=35, `out_cycles`=0. In (0, 0) → `out_c`=0.
- in (65535, 1) with a responder delaying final ack 20 cycles → `out_c`=1, `out_cycles`=23. `AB`=1 stable for the whole REQ_B/REL_B.
- `out_ready` held 0 for 10 cycles in DONE → `out_valid`, `out_c` and `out_cycles` unchanged, `in_ready`=0, and a new `in_valid` pulse is not accepted.
- reset asserted during REQ_B of (48, 36) → `req`=0, `out_valid`=0 immediately. Then (48, 36) re-sent → `out_c`=12.
- `CNT_W`=3 with a 20-cycle responder delay → `out_cycles`=7 (saturated, no wrap).
